// File: rtl/hazard_forward_unit.sv
// Data-hazard controller: per-operand forwarding selects for the EX muxes plus
// a load-use stall/bubble sequencer with memory-busy freeze and flush abort.
module hazard_forward_unit #(
  parameter int RA_W        = 3,
  parameter int NSRC        = 2,
  parameter int LU_STALL    = 1,
  parameter int CNT_W       = 16,
  parameter int ZERO_REG_EN = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC*RA_W-1:0]   id_src,
  input  logic [NSRC-1:0]        id_src_vld,
  input  logic [NSRC*RA_W-1:0]   ex_src,
  input  logic [NSRC-1:0]        ex_src_vld,
  input  logic [RA_W-1:0]        ex_rdst,
  input  logic                   ex_wb,
  input  logic                   ex_mem_rd,
  input  logic [RA_W-1:0]        mem_rdst,
  input  logic                   mem_wb,
  input  logic [RA_W-1:0]        wb_rdst,
  input  logic                   wb_wb,
  input  logic                   mem_busy,
  input  logic                   flush,
  output logic [NSRC*2-1:0]      exec_sel,
  output logic                   stall,
  output logic                   bubble,
  output logic [CNT_W-1:0]       stall_cnt
);

  typedef enum logic {ST_RUN, ST_LU} state_t;

  // Remaining bubbles after the first one, which is issued from RUN.
  localparam logic [3:0] LU_INIT = (LU_STALL > 1) ? 4'(LU_STALL - 2) : 4'd0;

  state_t      state_p0, state_nxt;
  logic [3:0]  cnt_p0, cnt_nxt;
  logic        lu_hit;

  function automatic logic addr_match(input logic [RA_W-1:0] a,
                                      input logic [RA_W-1:0] d,
                                      input logic            wb);
    return wb && (a == d) && !((ZERO_REG_EN != 0) && (d == '0));
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == '1) ? c : c + CNT_W'(1);
  endfunction

  always_comb begin
    exec_sel = '0;
    lu_hit   = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      // MEM holds the younger result, so it takes priority over WB.
      if (!rst && ex_src_vld[i]) begin
        if (addr_match(ex_src[i*RA_W +: RA_W], mem_rdst, mem_wb))
          exec_sel[i*2 +: 2] = 2'b01;
        else if (addr_match(ex_src[i*RA_W +: RA_W], wb_rdst, wb_wb))
          exec_sel[i*2 +: 2] = 2'b10;
      end
      if (id_src_vld[i] && addr_match(id_src[i*RA_W +: RA_W], ex_rdst, ex_wb))
        lu_hit = 1'b1;
    end
    lu_hit = lu_hit && ex_mem_rd;
  end

  always_comb begin
    state_nxt = state_p0;
    cnt_nxt   = cnt_p0;
    stall     = 1'b0;
    bubble    = 1'b0;
    if (!rst) begin
      case (state_p0)
        ST_RUN: begin
          if (flush) begin
            stall = 1'b0;
          end else if (mem_busy) begin
            stall = 1'b1;
          end else if (lu_hit) begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (LU_STALL > 1) begin
              state_nxt = ST_LU;
              cnt_nxt   = LU_INIT;
            end
          end
        end
        ST_LU: begin
          // The dependent instruction is squashed by flush, so abandon the sequence.
          if (flush) begin
            state_nxt = ST_RUN;
          end else if (mem_busy) begin
            stall = 1'b1;
          end else begin
            stall  = 1'b1;
            bubble = 1'b1;
            if (cnt_p0 == 4'd0)
              state_nxt = ST_RUN;
            else
              cnt_nxt = cnt_p0 - 4'd1;
          end
        end
        default: state_nxt = ST_RUN;
      endcase
    end
  end

  // Stage p0: sequencer state and stall statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0  <= ST_RUN;
      cnt_p0    <= 4'd0;
      stall_cnt <= '0;
    end else begin
      state_p0 <= state_nxt;
      cnt_p0   <= cnt_nxt;
      if (stall)
        stall_cnt <= sat_inc(stall_cnt);
    end
  end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Directed bench: two instances (LU_STALL=1/ZERO off/16-bit counter and
// LU_STALL=3/ZERO on/4-bit counter) share one set of stimulus inputs.
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  id_src;
  logic [1:0]  id_src_vld;
  logic [5:0]  ex_src;
  logic [1:0]  ex_src_vld;
  logic [2:0]  ex_rdst;
  logic        ex_wb, ex_mem_rd;
  logic [2:0]  mem_rdst, wb_rdst;
  logic        mem_wb, wb_wb, mem_busy, flush;

  logic [3:0]  sel_a, sel_b;
  logic        stall_a, stall_b, bubble_a, bubble_b;
  logic [15:0] cnt_a;
  logic [3:0]  cnt_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(.RA_W(3), .NSRC(2), .LU_STALL(1), .CNT_W(16), .ZERO_REG_EN(0)) u_dut_a (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_vld(id_src_vld),
    .ex_src(ex_src), .ex_src_vld(ex_src_vld), .ex_rdst(ex_rdst), .ex_wb(ex_wb),
    .ex_mem_rd(ex_mem_rd), .mem_rdst(mem_rdst), .mem_wb(mem_wb),
    .wb_rdst(wb_rdst), .wb_wb(wb_wb), .mem_busy(mem_busy), .flush(flush),
    .exec_sel(sel_a), .stall(stall_a), .bubble(bubble_a), .stall_cnt(cnt_a));

  hazard_forward_unit #(.RA_W(3), .NSRC(2), .LU_STALL(3), .CNT_W(4), .ZERO_REG_EN(1)) u_dut_b (
    .clk(clk), .rst(rst), .id_src(id_src), .id_src_vld(id_src_vld),
    .ex_src(ex_src), .ex_src_vld(ex_src_vld), .ex_rdst(ex_rdst), .ex_wb(ex_wb),
    .ex_mem_rd(ex_mem_rd), .mem_rdst(mem_rdst), .mem_wb(mem_wb),
    .wb_rdst(wb_rdst), .wb_wb(wb_wb), .mem_busy(mem_busy), .flush(flush),
    .exec_sel(sel_b), .stall(stall_b), .bubble(bubble_b), .stall_cnt(cnt_b));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_src = '0; id_src_vld = '0; ex_src = '0; ex_src_vld = '0;
    ex_rdst = '0; ex_wb = 0; ex_mem_rd = 0; mem_rdst = '0; mem_wb = 0;
    wb_rdst = '0; wb_wb = 0; mem_busy = 0; flush = 0;
  endtask

  task automatic set_hazard(input logic on);
    ex_mem_rd = on; ex_wb = on; ex_rdst = 3'd3;
    id_src = {3'd3, 3'd5}; id_src_vld = on ? 2'b10 : 2'b00;
  endtask

  task automatic do_reset();
    rst = 1; tick(); tick(); rst = 0;
  endtask

  initial begin
    clear_inputs();
    rst = 1;
    tick(); tick();
    // Outputs forced low while in reset, even with active causes.
    mem_busy = 1; ex_src = {3'd1, 3'd1}; ex_src_vld = 2'b11; mem_rdst = 3'd1; mem_wb = 1;
    #1;
    chk("rst_stall", stall_a, 0);
    chk("rst_sel", sel_a, 4'b0000);
    chk("rst_cnt_a", cnt_a, 0);
    chk("rst_cnt_b", cnt_b, 0);
    clear_inputs();
    tick();
    rst = 0;

    // Forwarding priority
    ex_src = {3'd1, 3'd1}; ex_src_vld = 2'b11;
    mem_rdst = 3'd1; mem_wb = 1; wb_rdst = 3'd1; wb_wb = 1;
    #1;
    chk("fwd_mem_beats_wb", sel_a, 4'b0101);
    chk("fwd_mem_beats_wb_b", sel_b, 4'b0101);
    mem_wb = 0; #1;
    chk("fwd_wb", sel_a, 4'b1010);
    ex_src_vld = 2'b01; #1;
    chk("fwd_vld_gate", sel_a, 4'b0010);

    // Zero register
    clear_inputs();
    ex_src = {3'd1, 3'd0}; ex_src_vld = 2'b01; mem_rdst = 3'd0; mem_wb = 1;
    #1;
    chk("zero_off", sel_a, 4'b0001);
    chk("zero_on", sel_b, 4'b0000);
    wb_rdst = 3'd0; wb_wb = 1; #1;
    chk("zero_on_wb", sel_b, 4'b0000);
    clear_inputs();

    // Load-use, LU_STALL=1
    set_hazard(0); ex_mem_rd = 1; ex_wb = 1; #1;
    chk("lu_no_vld", stall_a, 0);
    set_hazard(1); #1;
    chk("lu1_stall", stall_a, 1);
    chk("lu1_bubble", bubble_a, 1);
    tick();
    set_hazard(0); #1;
    chk("lu1_done_stall", stall_a, 0);
    chk("lu1_done_bubble", bubble_a, 0);
    chk("lu1_cnt", cnt_a, 1);
    clear_inputs();
    do_reset();

    // Load-use, LU_STALL=3 with mem_busy freeze in the 2nd cycle
    set_hazard(1); #1;
    chk("lu3_c1", {stall_b, bubble_b}, 2'b11);
    tick(); set_hazard(0); mem_busy = 1; #1;
    chk("lu3_c2", {stall_b, bubble_b}, 2'b10);
    tick(); mem_busy = 0; #1;
    chk("lu3_c3", {stall_b, bubble_b}, 2'b11);
    chk("lu3_cnt_mid", cnt_b, 2);
    tick(); #1;
    chk("lu3_c4", {stall_b, bubble_b}, 2'b11);
    tick(); #1;
    chk("lu3_c5", {stall_b, bubble_b}, 2'b00);
    chk("lu3_cnt", cnt_b, 4);
    clear_inputs();
    do_reset();

    // Flush abort in LU, then same-cycle flush and lu_hit
    set_hazard(1); #1;
    chk("fl_c1", {stall_b, bubble_b}, 2'b11);
    tick(); set_hazard(0); flush = 1; #1;
    chk("fl_c2", {stall_b, bubble_b}, 2'b00);
    tick(); flush = 0; #1;
    chk("fl_run", stall_b, 0);
    set_hazard(1); flush = 1; #1;
    chk("fl_same_a", stall_a, 0);
    chk("fl_same_b", stall_b, 0);
    tick(); set_hazard(0); flush = 0; #1;
    chk("fl_same_run", stall_b, 0);
    chk("fl_cnt", cnt_b, 1);
    clear_inputs();
    do_reset();

    // Counter saturation under a long memory freeze
    mem_busy = 1;
    repeat (20) tick();
    mem_busy = 0; #1;
    chk("sat_cnt_b", cnt_b, 15);
    chk("sat_cnt_a", cnt_a, 20);

    // Reset mid-LU
    set_hazard(1); #1;
    chk("rlu_c1", stall_b, 1);
    tick(); set_hazard(0); rst = 1; #1;
    chk("rlu_forced", {stall_b, bubble_b}, 2'b00);
    tick(); rst = 0; #1;
    chk("rlu_stall", {stall_b, bubble_b}, 2'b00);
    chk("rlu_cnt_b", cnt_b, 0);
    chk("rlu_cnt_a", cnt_a, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
